// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared state encoding and sizing helper for the count sequencer
package count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Prescaler register width; a divide-by-1 still needs one bit to exist.
    function automatic int pre_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - two-flop synchronizer plus history flop giving a one-cycle press pulse
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    // History resets low, so a button held through reset release still fires once.
    assign pulse = sync2_q & ~hist_q;

endmodule

// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - run/pause/clear sequencer with prescaled wrap or one-shot counter
module count_ctrl
    import count_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int CNT_W    = 4,
    parameter int CNT_MAX  = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_start,
    input  logic             btn_clr,
    input  logic             mode,
    output logic [CNT_W-1:0] cnt,
    output logic             tick,
    output logic             tc,
    output logic             running,
    output logic             done
);

    localparam int               PRE_W    = pre_width(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);

    logic             start_ev, clr_ev;
    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    btn_edge u_start (.clk(clk), .rst(rst), .din(btn_start), .pulse(start_ev));
    btn_edge u_clr   (.clk(clk), .rst(rst), .din(btn_clr),   .pulse(clr_ev));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // Pause/stop on a tick cycle takes priority: the pending step is dropped.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        if (clr_ev) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ev) begin
                        state_d = ST_RUN;
                        pre_d   = '0;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (start_ev) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        pre_d = '0;
                        if (cnt_q != CNT_TOP) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end else if (mode) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = '0;
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start_ev) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tick      = (state_q == ST_RUN) && (pre_q == PRE_LAST);
        tc        = tick && (cnt_q == CNT_TOP);
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    assign cnt     = cnt_q;
    assign running = running_q;
    assign done    = done_q;

endmodule
